// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared widths, constants and read-port mux for the MIPS
//               write-back register file.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    localparam int RegNum = 32;

    typedef logic [4:0]  reg_addr_t;   // RegAddrBus
    typedef logic [31:0] reg_data_t;   // RegBus

    localparam reg_data_t ZeroWord     = 32'h0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam logic      ReadEnable   = 1'b1;
    localparam logic      ReadDisable  = 1'b0;

    // Priority: reset, disabled port, $0, same-cycle write-back, stored value.
    function automatic reg_data_t read_port(
        input logic      rst,
        input logic      re,
        input reg_addr_t raddr,
        input logic      wreg,
        input reg_addr_t wd,
        input reg_data_t wdata,
        input reg_data_t stored
    );
        if (rst) begin
            return ZeroWord;
        end else if (re == ReadDisable) begin
            return ZeroWord;
        end else if (raddr == '0) begin
            return ZeroWord;
        end else if (wreg == WriteEnable && wd == raddr) begin
            return wdata;
        end
        return stored;
    endfunction

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/hilo_reg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_reg
// Description : HI/LO register pair with write-first bypass on its outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_whilo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    reg_data_t r_hi;
    reg_data_t r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= ZeroWord;
            r_lo <= ZeroWord;
        end else if (wb_whilo == WriteEnable) begin
            r_hi <= wb_hi;
            r_lo <= wb_lo;
        end
    end

    always_comb begin
        hi_o = r_hi;
        lo_o = r_lo;
        if (rst) begin
            hi_o = ZeroWord;
            lo_o = ZeroWord;
        end else if (wb_whilo == WriteEnable) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end
    end

endmodule : hilo_reg
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : MEM/WB write-back target: 32x32 GPR file with two bypassed
//               combinational read ports, plus the HI/LO pair.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic        wb_whilo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Entry 0 is only ever cleared; reads of $0 are also forced to zero.
    reg_data_t r_regs [0:RegNum-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RegNum; i++) begin
                r_regs[i] <= ZeroWord;
            end
        end else if (wb_wreg != WriteDisable && wb_wd != '0) begin
            r_regs[wb_wd] <= wb_wdata;
        end
    end

    assign rdata1 = read_port(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, r_regs[raddr1]);
    assign rdata2 = read_port(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, r_regs[raddr2]);

    hilo_reg u_hilo_reg (
        .clk      (clk),
        .rst      (rst),
        .wb_whilo (wb_whilo),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

endmodule : wb_regfile
`default_nettype wire
